bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 32 +++
 rtl/bus_timer.sv | 26 ++
 rtl/bus_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared constants, state encoding and RAM request payload for the bus arbiter.
package bus_arbiter_pkg;

  localparam int unsigned REG_BUS = 32;
  localparam int unsigned SEL_W   = 4;

  localparam logic [REG_BUS-1:0] ZERO_WORD     = '0;
  localparam logic               CHIP_ENABLE   = 1'b1;
  localparam logic               CHIP_DISABLE  = 1'b0;
  localparam logic               WRITE_ENABLE  = 1'b1;
  localparam logic               WRITE_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_INST = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic               we;
    logic [REG_BUS-1:0] addr;
    logic [SEL_W-1:0]   sel;
    logic [REG_BUS-1:0] wdata;
  } ram_req_t;

  // Instruction fetches are always whole, word-aligned reads.
  function automatic logic [REG_BUS-1:0] word_align(input logic [REG_BUS-1:0] addr);
    return addr & ~REG_BUS'(3);
  endfunction

endpackage

// File: rtl/bus_timer.sv
// Wait-cycle counter; expired fires on the cycle whose increment reaches TIMEOUT_CYCLES.
module bus_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired = en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access; data has priority.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inst_ce_i,
  input  logic [REG_BUS-1:0] inst_addr_i,
  output logic [REG_BUS-1:0] inst_data_o,
  output logic               stallreq_inst_o,
  input  logic               data_ce_i,
  input  logic               data_we_i,
  input  logic [REG_BUS-1:0] data_addr_i,
  input  logic [SEL_W-1:0]   data_sel_i,
  input  logic [REG_BUS-1:0] data_wdata_i,
  output logic [REG_BUS-1:0] data_rdata_o,
  output logic               stallreq_data_o,
  input  logic               flush_i,
  output logic               ram_ce_o,
  output logic               ram_we_o,
  output logic [REG_BUS-1:0] ram_addr_o,
  output logic [SEL_W-1:0]   ram_sel_o,
  output logic [REG_BUS-1:0] ram_wdata_o,
  input  logic [REG_BUS-1:0] ram_rdata_i,
  input  logic               ram_ack_i,
  output logic               bus_err_o
);

  arb_state_e         state_q;
  ram_req_t           ram_req_q;
  logic               ram_ce_q;
  logic [REG_BUS-1:0] inst_data_q;
  logic [REG_BUS-1:0] data_rdata_q;
  logic               bus_err_q;
  logic               last_data_q;
  logic               flushed_q;

  logic busy;
  logic timer_expired;
  logic inst_dropped;

  assign busy         = (state_q == ST_DATA) || (state_q == ST_INST);
  assign inst_dropped = flushed_q || flush_i;

  bus_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (!busy),
    .en     (busy && !ram_ack_i),
    .expired(timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ram_req_q    <= '0;
      ram_ce_q     <= CHIP_DISABLE;
      inst_data_q  <= ZERO_WORD;
      data_rdata_q <= ZERO_WORD;
      bus_err_q    <= 1'b0;
      last_data_q  <= 1'b0;
      flushed_q    <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          flushed_q <= 1'b0;
          if (data_ce_i) begin
            state_q     <= ST_DATA;
            ram_ce_q    <= CHIP_ENABLE;
            ram_req_q   <= '{we: data_we_i, addr: data_addr_i,
                             sel: data_sel_i, wdata: data_wdata_i};
            last_data_q <= 1'b1;
          end else if (inst_ce_i) begin
            state_q     <= ST_INST;
            ram_ce_q    <= CHIP_ENABLE;
            ram_req_q   <= '{we: WRITE_DISABLE, addr: word_align(inst_addr_i),
                             sel: '1, wdata: ZERO_WORD};
            last_data_q <= 1'b0;
          end
        end
        ST_DATA: begin
          if (ram_ack_i) begin
            if (ram_req_q.we != WRITE_ENABLE) data_rdata_q <= ram_rdata_i;
            ram_ce_q <= CHIP_DISABLE;
            state_q  <= ST_DONE;
          end else if (timer_expired) begin
            data_rdata_q <= ZERO_WORD;
            bus_err_q    <= 1'b1;
            ram_ce_q     <= CHIP_DISABLE;
            state_q      <= ST_DONE;
          end
        end
        ST_INST: begin
          // A flushed fetch still finishes on the bus but its result is discarded.
          if (flush_i) flushed_q <= 1'b1;
          if (ram_ack_i) begin
            if (!inst_dropped) inst_data_q <= ram_rdata_i;
            ram_ce_q <= CHIP_DISABLE;
            state_q  <= inst_dropped ? ST_IDLE : ST_DONE;
          end else if (timer_expired) begin
            if (!inst_dropped) inst_data_q <= ZERO_WORD;
            bus_err_q <= 1'b1;
            ram_ce_q  <= CHIP_DISABLE;
            state_q   <= inst_dropped ? ST_IDLE : ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ram_ce_o     = ram_ce_q;
  assign ram_we_o     = ram_req_q.we;
  assign ram_addr_o   = ram_req_q.addr;
  assign ram_sel_o    = ram_req_q.sel;
  assign ram_wdata_o  = ram_req_q.wdata;
  assign inst_data_o  = inst_data_q;
  assign data_rdata_o = data_rdata_q;
  assign bus_err_o    = bus_err_q;

  // Stall releases only during the DONE cycle of the requester's own transaction.
  assign stallreq_data_o = !rst && data_ce_i && !((state_q == ST_DONE) && last_data_q);
  assign stallreq_inst_o = !rst && inst_ce_i && !((state_q == ST_DONE) && !last_data_q);

endmodule
